// File: rtl/spi_slave_modes.sv
// -----------------------------------------------------------------------------
// spi_slave_modes
//   SPI slave supporting all four CPOL/CPHA modes, with a one-byte transmit
//   holding register and a received-byte strobe. All SPI bus inputs are
//   asynchronous and are re-timed into the clk domain before use.
//
// Ports
//   clk          system clock, all state updates on its rising edge
//   reset        asynchronous active-low reset
//   cpol, cpha   SPI mode select, latched only while synchronized cs is high
//   sclk, mosi   serial clock and data from the master (asynchronous)
//   cs           chip select from the master, active-low (asynchronous)
//   miso         serial data to the master, MSB first
//   so_data      byte to transmit
//   so_start     write strobe for so_data
//   so_ready     holding register empty
//   si_data      last completely received byte
//   si_done      one-cycle strobe when si_data is updated
//   o_dbg_state  current FSM state (IDLE/ARMED/SHIFT) for observation
//
// Transmit handshake: so_start acts as "valid" and so_ready as "ready". A byte
// is accepted on a rising clk edge where so_start=1 and so_ready=1; so_start
// while so_ready=0 is ignored and the caller must hold or retry.
//
// Configuration macro: SPI_SLAVE_MISO_TRISTATE_EN
//   defined   : miso is 1'bz while synchronized cs is high or reset is low
//   undefined : miso is 0 while synchronized cs is high
// -----------------------------------------------------------------------------
module spi_slave_modes (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpol,
  input  logic       cpha,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       cs,
  output logic       miso,
  input  logic [7:0] so_data,
  input  logic       so_start,
  output logic       so_ready,
  output logic [7:0] si_data,
  output logic       si_done,
  output logic [1:0] o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  // Synchronizers plus one extra stage for edge detection on sclk and cs.
  logic r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic r_mosi_s1, r_mosi_s2;
  logic r_cs_s1, r_cs_s2, r_cs_d;

  logic r_cpol, r_cpha;

  logic [7:0] r_hold;
  logic       r_hold_full;
  logic [7:0] r_tx_sr;
  logic [7:0] r_rx_sr;
  logic [2:0] r_bit_cnt;
  logic       r_miso;

  logic       w_sclk_rise, w_sclk_fall;
  logic       w_cs_rise, w_cs_fall;
  logic       w_lead, w_trail;
  logic       w_sample_edge, w_shift_edge;
  logic       w_in_byte;
  logic       w_do_sample, w_do_shift;
  logic       w_byte_done;
  logic       w_hold_move;
  logic [7:0] w_tx_byte;
  logic [7:0] w_rx_next;
  logic       w_miso_bit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_d  <= 1'b0;
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
      r_cs_s1   <= 1'b1;
      r_cs_s2   <= 1'b1;
      r_cs_d    <= 1'b1;
    end else begin
      r_sclk_s1 <= sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_d  <= r_sclk_s2;
      r_mosi_s1 <= mosi;
      r_mosi_s2 <= r_mosi_s1;
      r_cs_s1   <= cs;
      r_cs_s2   <= r_cs_s1;
      r_cs_d    <= r_cs_s2;
    end
  end

  // Mode is frozen for the whole time the slave is selected.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cpol <= 1'b0;
      r_cpha <= 1'b0;
    end else if (r_cs_s2) begin
      r_cpol <= cpol;
      r_cpha <= cpha;
    end
  end

  assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;
  assign w_sclk_fall = ~r_sclk_s2 & r_sclk_d;
  assign w_cs_fall   = ~r_cs_s2 & r_cs_d;
  assign w_cs_rise   = r_cs_s2 & ~r_cs_d;

  assign w_lead        = r_cpol ? w_sclk_fall : w_sclk_rise;
  assign w_trail       = r_cpol ? w_sclk_rise : w_sclk_fall;
  assign w_sample_edge = r_cpha ? w_trail : w_lead;
  assign w_shift_edge  = r_cpha ? w_lead : w_trail;

  // A byte starts on its leading edge. In ARMED a trailing edge is the tail
  // of the previous byte (cpha=0 back-to-back) and is ignored so it cannot
  // disturb the freshly loaded MSB.
  assign w_in_byte   = (r_state == SHIFT) || ((r_state == ARMED) && w_lead);
  assign w_do_sample = w_in_byte && w_sample_edge && !w_cs_rise;
  assign w_do_shift  = w_in_byte && w_shift_edge && !w_cs_rise;
  assign w_byte_done = w_do_sample && (r_bit_cnt == 3'd7);

  // The holding register drains into the shift register only before the
  // byte's first edge; the cycle of that edge may still use it directly.
  assign w_hold_move = (r_state == ARMED) && r_hold_full && !w_cs_rise;
  assign w_tx_byte   = ((r_state == ARMED) && r_hold_full) ? r_hold : r_tx_sr;
  assign w_rx_next   = {r_rx_sr[6:0], r_mosi_s2};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_cs_fall)   w_next = ARMED;
      ARMED:   if (w_lead)      w_next = SHIFT;
      SHIFT:   if (w_byte_done) w_next = ARMED;
      default:                  w_next = IDLE;
    endcase
    if (w_cs_rise) begin
      w_next = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hold      <= 8'h00;
      r_hold_full <= 1'b0;
    end else if (so_start && !r_hold_full) begin
      r_hold      <= so_data;
      r_hold_full <= 1'b1;
    end else if (w_hold_move) begin
      r_hold_full <= 1'b0;
    end
  end

  // Transmit path. Any chip-select change or completed byte clears the shift
  // register so an unloaded byte goes out as 8'h00.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_sr <= 8'h00;
      r_miso  <= 1'b0;
    end else if (w_cs_rise || w_cs_fall) begin
      r_tx_sr <= 8'h00;
      r_miso  <= 1'b0;
    end else if (w_byte_done) begin
      r_tx_sr <= 8'h00;
    end else if (w_do_shift) begin
      r_miso  <= w_tx_byte[7];
      r_tx_sr <= {w_tx_byte[6:0], 1'b0};
    end else if (w_hold_move) begin
      r_tx_sr <= r_hold;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_sr   <= 8'h00;
      r_bit_cnt <= 3'd0;
      si_data   <= 8'h00;
      si_done   <= 1'b0;
    end else begin
      si_done <= 1'b0;
      if (w_cs_rise || w_cs_fall) begin
        r_bit_cnt <= 3'd0;
      end else if (w_do_sample) begin
        r_rx_sr   <= w_rx_next;
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          si_data <= w_rx_next;
          si_done <= 1'b1;
        end
      end
    end
  end

  // cpha=0 shows the MSB before the first edge, so miso comes straight from
  // the shift register; cpha=1 presents a new bit after each leading edge.
  assign w_miso_bit = r_cpha ? r_miso : r_tx_sr[7];

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign miso = (!reset || r_cs_s2) ? 1'bz : w_miso_bit;
`else
  assign miso = r_cs_s2 ? 1'b0 : w_miso_bit;
`endif

  assign so_ready    = ~r_hold_full;
  assign o_dbg_state = r_state;

endmodule

// File: doc/spi_slave_modes.md
SPI_SLAVE_MODES -- requirements
Module: spi_slave_modes

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: system clock; all state is updated on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the ports cpol and cpha, input, 1 bit each: SPI mode select, sampled only while cs is high.
REQ-004 The block SHALL have the ports sclk, mosi and cs, input, 1 bit each: asynchronous bus inputs from the master; cs is active-low.
REQ-005 The block SHALL have the port miso, output, 1 bit: serial data to the master, MSB first.
REQ-006 The block SHALL have the ports so_data (input, 8 bits), so_start (input, 1 bit) and so_ready (output, 1 bit): the transmit byte handshake.
REQ-007 The block SHALL have the ports si_data (output, 8 bits) and si_done (output, 1 bit): the received byte and its 1-cycle strobe.

Function
REQ-008 sclk, mosi and cs SHALL each pass through a 2-flop synchronizer, followed by edge detection on the synchronized sclk and cs.
REQ-009 Edge roles SHALL be fixed as follows:
- leading edge = rising when cpol=0, falling when cpol=1;
- sample edge = leading when cpha=0, trailing when cpha=1;
- shift edge = the other edge.
REQ-010 The FSM SHALL have three states, IDLE, ARMED and SHIFT:
- IDLE -> ARMED on synchronized cs fall;
- ARMED -> SHIFT on the first sclk edge;
- SHIFT -> ARMED after the 8th sample edge while cs is low;
- any state -> IDLE on cs rise.
REQ-011 A transmit holding register SHALL provide buffering: so_ready=1 when the register is empty, and so_start with so_ready=1 writes so_data into it; so_start with so_ready=0 SHALL be ignored.
REQ-012 While in ARMED with no sclk edge yet seen for the current byte, a full holding register SHALL move to the shift register in the same cycle, emptying the holding register.
- This includes a so_start that arrives after cs falls.
REQ-013 If the holding register is empty when the first sclk edge of a byte arrives, the shift register SHALL send 8'h00.
REQ-014 When cpha=0, miso SHALL present shift-register bit 7 while in ARMED, and SHALL advance one bit on each shift edge.
REQ-015 When cpha=1, miso SHALL update to the next bit on each leading (shift) edge, starting with bit 7 on the first leading edge.
REQ-016 Each sample edge SHALL shift synchronized mosi into the LSB of the receive shift register and increment a 3-bit bit counter.
REQ-017 On the 8th sample edge, si_data SHALL load the full byte and si_done SHALL pulse high for exactly 1 clk cycle.
- si_done asserts at most 4 clk cycles after the raw sclk edge.
REQ-018 si_data SHALL hold its value until the next completed byte.
REQ-019 A cs rise before 8 sample edges SHALL abort the byte:
- no si_done pulse and si_data unchanged;
- bit counter cleared;
- partial transmit byte discarded; the holding register keeps its contents.
REQ-020 Back-to-back bytes under continuous cs-low SHALL be supported, with the counter wrapping 7 -> 0 and re-entering ARMED.
REQ-021 Operation SHALL be guaranteed for an sclk period of at least 8 clk cycles, with each phase of at least 4 clk cycles.

Reset
REQ-022 While reset=0, the following SHALL hold asynchronously:
- state = IDLE;
- miso = 0, si_data = 8'h00, si_done = 0, so_ready = 1;
- holding register empty; shift registers, counter and synchronizers cleared, with the cs synchronizer set to 1.
REQ-023 A reset asserted mid-byte SHALL abort the byte with no si_done pulse.
REQ-024 After reset is released, the block SHALL wait in IDLE until the next cs fall.

Configuration
REQ-025 With macro SPI_SLAVE_MISO_TRISTATE_EN defined, miso SHALL drive 1'bz whenever synchronized cs is high or reset=0.
REQ-026 Without SPI_SLAVE_MISO_TRISTATE_EN, miso SHALL drive 0 when cs is high; the rest of the behaviour is identical.

Verification
REQ-027 Mode 0: the master sends 8'hF0 while so_start loads 8'h0F -> slave si_data=8'hF0 with one si_done pulse, and the master receives 8'h0F.
REQ-028 Modes 1, 2 and 3 in turn: the master sends 8'hA5 while the slave loads 8'h5A -> si_data=8'hA5 and the master receives 8'h5A in every mode.
REQ-029 Back-to-back bytes under one cs-low: the master sends 8'h12 then 8'h34, the slave loads 8'hC3 then 8'h3C -> two si_done pulses (8'h12, 8'h34), the master receives 8'hC3 then 8'h3C, and so_ready re-asserts between the bytes.
REQ-030 cs abort: cs rises after 4 sclk cycles of 8'hFF -> no si_done and si_data stays at its prior value; a following full 8'h81 transfer -> si_data=8'h81.
REQ-031 No so_start issued: the master sends 8'h55 -> the master receives 8'h00 and si_data=8'h55.
REQ-032 Mid-byte reset: reset is pulled low after 3 sample edges -> si_data=8'h00, si_done is never asserted, and miso=0, or z when SPI_SLAVE_MISO_TRISTATE_EN is defined.
